// File: rtl/gecko_load_store_unit.sv
// Gecko memory stage: formats loads/stores into word-aligned memory requests and retires loads in order.
// Optional misaligned-access trap enabled by defining GECKO_LSU_MISALIGN_TRAP_EN (adds exc_valid/exc_addr).

module gecko_lsu_chk (
    input logic clk,
    input logic rst,
    input logic i_resp_valid,
    input logic i_resp_has_entry
);
    a_resp_has_entry: assert property (@(posedge clk) disable iff (rst) i_resp_valid |-> i_resp_has_entry);
endmodule

module gecko_load_store_unit #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_is_store,
    input  logic [2:0]                         cmd_op,
    input  logic [31:0]                        cmd_addr,
    input  logic [31:0]                        cmd_value,
    input  logic [4:0]                         cmd_rd_addr,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic                               mem_req_write,
    output logic [31:0]                        mem_req_addr,
    output logic [31:0]                        mem_req_wdata,
    output logic [3:0]                         mem_req_wmask,
    input  logic                               mem_resp_valid,
    input  logic [31:0]                        mem_resp_data,
    output logic                               wb_valid,
    input  logic                               wb_ready,
    output logic [4:0]                         wb_rd_addr,
    output logic [31:0]                        wb_rd_value,
    output logic [$clog2(MAX_OUTSTANDING):0]   loads_pending
`ifdef GECKO_LSU_MISALIGN_TRAP_EN
    ,
    output logic                               exc_valid,
    output logic [31:0]                        exc_addr
`endif
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [1:0] off,
                                              input logic [31:0] value);
        logic [31:0] res;
        case (size)
            2'b00:   res = {24'd0, value[7:0]} << {off, 3'b000};
            2'b01:   res = {16'd0, value[15:0]} << {off[1], 4'b0000};
            default: res = value;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] fmt_wmask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] res;
        case (size)
            2'b00:   res = 4'b0001 << off;
            2'b01:   res = 4'b0011 << {off[1], 1'b0};
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                                 input logic [31:0] data);
        logic [31:0] byte_s;
        logic [31:0] half_s;
        logic [31:0] res;
        byte_s = data >> {off, 3'b000};
        half_s = data >> {off[1], 4'b0000};
        case (op)
            OP_B:    res = {{24{byte_s[7]}}, byte_s[7:0]};
            OP_BU:   res = {24'd0, byte_s[7:0]};
            OP_H:    res = {{16{half_s[15]}}, half_s[15:0]};
            OP_HU:   res = {16'd0, half_s[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

    logic                        r_req_valid;
    logic                        r_req_write;
    logic [31:0]                 r_req_addr;
    logic [31:0]                 r_req_wdata;
    logic [3:0]                  r_req_wmask;
    logic [PW-1:0]               r_alloc_ptr;
    logic [PW-1:0]               r_fill_ptr;
    logic [PW-1:0]               r_head_ptr;
    logic [CW-1:0]               r_pending;
    logic [MAX_OUTSTANDING-1:0]  r_alloc_v;
    logic [MAX_OUTSTANDING-1:0]  r_filled;
    logic [2:0]                  r_op   [MAX_OUTSTANDING];
    logic [1:0]                  r_off  [MAX_OUTSTANDING];
    logic [4:0]                  r_rd   [MAX_OUTSTANDING];
    logic [31:0]                 r_data [MAX_OUTSTANDING];
    logic                        r_wb_valid;
    logic [4:0]                  r_wb_rd;
    logic [31:0]                 r_wb_value;

    logic          w_misalign;
    logic          w_accept;
    logic          w_issue;
    logic          w_alloc;
    logic          w_fill;
    logic          w_free;
    logic [PW-1:0] w_src_ptr;
    logic          w_src_ready;
    logic [31:0]   w_src_data;
    logic          w_wb_load;

`ifdef GECKO_LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((cmd_op[1:0] == 2'b01) && cmd_addr[0]) ||
                        ((cmd_op[1:0] == 2'b10) && (cmd_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Load credit uses the registered count, so a same-cycle free never opens a full buffer.
    assign cmd_ready = !rst && (!r_req_valid || mem_req_ready) &&
                       (cmd_is_store || (r_pending < CW'(MAX_OUTSTANDING)));
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_issue   = w_accept && !w_misalign;
    assign w_alloc   = w_issue && !cmd_is_store;
    assign w_fill    = mem_resp_valid && r_alloc_v[r_fill_ptr] && !r_filled[r_fill_ptr];
    assign w_free    = r_wb_valid && wb_ready;

    // Pick the entry that feeds the writeback register next, bypassing a same-cycle response.
    always_comb begin
        w_src_ptr   = w_free ? (r_head_ptr + PW'(1)) : r_head_ptr;
        w_src_ready = r_alloc_v[w_src_ptr] &&
                      (r_filled[w_src_ptr] || (w_fill && (r_fill_ptr == w_src_ptr)));
        w_src_data  = r_filled[w_src_ptr] ? r_data[w_src_ptr] : mem_resp_data;
        w_wb_load   = (!r_wb_valid || w_free) && w_src_ready;
    end

    // Request stage register, held until memory accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= 32'd0;
            r_req_wdata <= 32'd0;
            r_req_wmask <= 4'b0000;
        end else if (w_issue) begin
            r_req_valid <= 1'b1;
            r_req_write <= cmd_is_store;
            r_req_addr  <= {cmd_addr[31:2], 2'b00};
            r_req_wdata <= cmd_is_store ? fmt_wdata(cmd_op[1:0], cmd_addr[1:0], cmd_value) : 32'd0;
            r_req_wmask <= cmd_is_store ? fmt_wmask(cmd_op[1:0], cmd_addr[1:0]) : 4'b0000;
        end else if (mem_req_ready) begin
            r_req_valid <= 1'b0;
        end else begin
            r_req_valid <= r_req_valid;
        end
    end

    // Completion buffer: allocate on load issue, fill on response, free on writeback handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_pending   <= '0;
            r_alloc_v   <= '0;
            r_filled    <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_op[i]   <= 3'd0;
                r_off[i]  <= 2'd0;
                r_rd[i]   <= 5'd0;
                r_data[i] <= 32'd0;
            end
        end else begin
            if (w_alloc) begin
                r_alloc_v[r_alloc_ptr] <= 1'b1;
                r_filled[r_alloc_ptr]  <= 1'b0;
                r_op[r_alloc_ptr]      <= cmd_op;
                r_off[r_alloc_ptr]     <= cmd_addr[1:0];
                r_rd[r_alloc_ptr]      <= cmd_rd_addr;
                r_alloc_ptr            <= r_alloc_ptr + PW'(1);
            end else begin
                r_alloc_ptr <= r_alloc_ptr;
            end
            if (w_fill) begin
                r_data[r_fill_ptr]   <= mem_resp_data;
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PW'(1);
            end else begin
                r_fill_ptr <= r_fill_ptr;
            end
            if (w_free) begin
                r_alloc_v[r_head_ptr] <= 1'b0;
                r_filled[r_head_ptr]  <= 1'b0;
                r_head_ptr            <= r_head_ptr + PW'(1);
            end else begin
                r_head_ptr <= r_head_ptr;
            end
            case ({w_alloc, w_free})
                2'b10:   r_pending <= r_pending + CW'(1);
                2'b01:   r_pending <= r_pending - CW'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Writeback output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_value <= 32'd0;
        end else if (w_wb_load) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd[w_src_ptr];
            r_wb_value <= load_extract(r_op[w_src_ptr], r_off[w_src_ptr], w_src_data);
        end else if (w_free) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= r_wb_valid;
        end
    end

`ifdef GECKO_LSU_MISALIGN_TRAP_EN
    logic        r_exc_valid;
    logic [31:0] r_exc_addr;

    // One-cycle exception pulse for an accepted misaligned access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_valid <= 1'b0;
            r_exc_addr  <= 32'd0;
        end else if (w_accept && w_misalign) begin
            r_exc_valid <= 1'b1;
            r_exc_addr  <= cmd_addr;
        end else begin
            r_exc_valid <= 1'b0;
            r_exc_addr  <= r_exc_addr;
        end
    end

    assign exc_valid = r_exc_valid;
    assign exc_addr  = r_exc_addr;
`endif

    assign mem_req_valid = r_req_valid;
    assign mem_req_write = r_req_write;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_wmask = r_req_wmask;
    assign wb_valid      = r_wb_valid;
    assign wb_rd_addr    = r_wb_rd;
    assign wb_rd_value   = r_wb_value;
    assign loads_pending = r_pending;

    gecko_lsu_chk u_chk (
        .clk              (clk),
        .rst              (rst),
        .i_resp_valid     (mem_resp_valid),
        .i_resp_has_entry (w_fill)
    );
endmodule

// File: tb/tb_gecko_load_store_unit.sv
// Directed self-checking bench for gecko_load_store_unit with hand-computed expected values.
`timescale 1ns/1ps
module tb_gecko_load_store_unit;
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_is_store;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_value;
    logic [4:0]  cmd_rd_addr;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_value;
    logic [2:0]  loads_pending;
`ifdef GECKO_LSU_MISALIGN_TRAP_EN
    logic        exc_valid;
    logic [31:0] exc_addr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gecko_load_store_unit #(.MAX_OUTSTANDING(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_is_store   (cmd_is_store),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_value      (cmd_value),
        .cmd_rd_addr    (cmd_rd_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rd_addr     (wb_rd_addr),
        .wb_rd_value    (wb_rd_value),
        .loads_pending  (loads_pending)
`ifdef GECKO_LSU_MISALIGN_TRAP_EN
        ,
        .exc_valid      (exc_valid),
        .exc_addr       (exc_addr)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and wait (bounded) until it is accepted.
    task automatic do_cmd(input logic st, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] value, input logic [4:0] rd);
        int n;
        cmd_is_store = st;
        cmd_op       = op;
        cmd_addr     = addr;
        cmd_value    = value;
        cmd_rd_addr  = rd;
        cmd_valid    = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("cmd_accept_wait", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_is_store = 1'b0; cmd_op = OP_B;
        cmd_addr = 32'd0; cmd_value = 32'd0; cmd_rd_addr = 5'd0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'd0; wb_ready = 1'b1;
        tick(); tick();
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_pending", {29'd0, loads_pending}, 32'd0);
        rst = 1'b0;

        // Byte and half stores
        do_cmd(1'b1, OP_B, 32'h0000_1003, 32'h0000_00AB, 5'd0);
        check_eq("sb_valid", {31'd0, mem_req_valid}, 32'd1);
        check_eq("sb_write", {31'd0, mem_req_write}, 32'd1);
        check_eq("sb_addr", mem_req_addr, 32'h0000_1000);
        check_eq("sb_wdata", mem_req_wdata, 32'hAB00_0000);
        check_eq("sb_wmask", {28'd0, mem_req_wmask}, 32'h8);
        tick();
        check_eq("sb_drained", {31'd0, mem_req_valid}, 32'd0);
        do_cmd(1'b1, OP_H, 32'h0000_0002, 32'h1234_BEEF, 5'd0);
        check_eq("sh_wdata", mem_req_wdata, 32'hBEEF_0000);
        check_eq("sh_wmask", {28'd0, mem_req_wmask}, 32'hC);

        // LH then LHU, second allocated in the same cycle the first is freed
        do_cmd(1'b0, OP_H, 32'h0000_2002, 32'd0, 5'd5);
        check_eq("lh_req_addr", mem_req_addr, 32'h0000_2000);
        check_eq("lh_req_write", {31'd0, mem_req_write}, 32'd0);
        check_eq("lh_req_wmask", {28'd0, mem_req_wmask}, 32'd0);
        check_eq("lh_pending", {29'd0, loads_pending}, 32'd1);
        resp(32'h8001_0000);
        check_eq("lh_wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("lh_wb_rd", {27'd0, wb_rd_addr}, 32'd5);
        check_eq("lh_wb_value", wb_rd_value, 32'hFFFF_8001);
        do_cmd(1'b0, OP_HU, 32'h0000_2002, 32'd0, 5'd6);
        check_eq("alloc_free_pending", {29'd0, loads_pending}, 32'd1);
        check_eq("alloc_free_wb_valid", {31'd0, wb_valid}, 32'd0);
        resp(32'h8001_0000);
        check_eq("lhu_wb_rd", {27'd0, wb_rd_addr}, 32'd6);
        check_eq("lhu_wb_value", wb_rd_value, 32'h0000_8001);
        tick();
        check_eq("lhu_freed_pending", {29'd0, loads_pending}, 32'd0);
        check_eq("lhu_freed_wb", {31'd0, wb_valid}, 32'd0);

        // Fill the buffer with writeback stalled
        wb_ready = 1'b0;
        do_cmd(1'b0, OP_B,  32'h0000_0101, 32'd0, 5'd1);
        do_cmd(1'b0, OP_BU, 32'h0000_0101, 32'd0, 5'd2);
        do_cmd(1'b0, OP_W,  32'h0000_0200, 32'd0, 5'd3);
        do_cmd(1'b0, OP_H,  32'h0000_0300, 32'd0, 5'd0);
        check_eq("full_pending", {29'd0, loads_pending}, 32'd4);
        cmd_is_store = 1'b0;
        #1;
        check_eq("full_load_ready", {31'd0, cmd_ready}, 32'd0);
        do_cmd(1'b1, OP_B, 32'h0000_0000, 32'h0000_0055, 5'd0);
        check_eq("full_store_wdata", mem_req_wdata, 32'h0000_0055);
        check_eq("full_store_wmask", {28'd0, mem_req_wmask}, 32'h1);
        check_eq("full_store_pending", {29'd0, loads_pending}, 32'd4);
        resp(32'h0000_9A00);
        resp(32'h0000_9A00);
        resp(32'hCAFE_F00D);
        resp(32'h0000_8123);
        tick();
        check_eq("held_wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("held_wb_rd", {27'd0, wb_rd_addr}, 32'd1);
        check_eq("held_wb_value", wb_rd_value, 32'hFFFF_FF9A);
        check_eq("held_pending", {29'd0, loads_pending}, 32'd4);
        cmd_is_store = 1'b0;
        wb_ready = 1'b1;
        #1;
        check_eq("full_free_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        check_eq("beat2_rd", {27'd0, wb_rd_addr}, 32'd2);
        check_eq("beat2_value", wb_rd_value, 32'h0000_009A);
        check_eq("beat2_pending", {29'd0, loads_pending}, 32'd3);
        check_eq("beat2_load_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        check_eq("beat3_rd", {27'd0, wb_rd_addr}, 32'd3);
        check_eq("beat3_value", wb_rd_value, 32'hCAFE_F00D);
        tick();
        check_eq("beat4_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("beat4_rd", {27'd0, wb_rd_addr}, 32'd0);
        check_eq("beat4_value", wb_rd_value, 32'hFFFF_8123);
        tick();
        check_eq("drained_wb", {31'd0, wb_valid}, 32'd0);
        check_eq("drained_pending", {29'd0, loads_pending}, 32'd0);

        // Memory backpressure, then reset mid-operation
        do_cmd(1'b0, OP_W, 32'h0000_0400, 32'd0, 5'd7);
        tick();
        mem_req_ready = 1'b0;
        do_cmd(1'b1, OP_W, 32'h0000_0004, 32'hDEAD_BEEF, 5'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid", {31'd0, mem_req_valid}, 32'd1);
            check_eq("stall_addr", mem_req_addr, 32'h0000_0004);
            check_eq("stall_wdata", mem_req_wdata, 32'hDEAD_BEEF);
            check_eq("stall_wmask", {28'd0, mem_req_wmask}, 32'hF);
            check_eq("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        check_eq("pre_rst_pending", {29'd0, loads_pending}, 32'd1);
        rst = 1'b1;
        tick();
        check_eq("midrst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check_eq("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("midrst_pending", {29'd0, loads_pending}, 32'd0);
        check_eq("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef GECKO_LSU_MISALIGN_TRAP_EN
        do_cmd(1'b0, OP_W, 32'h0000_3001, 32'd0, 5'd8);
        check_eq("trap_exc_valid", {31'd0, exc_valid}, 32'd1);
        check_eq("trap_exc_addr", exc_addr, 32'h0000_3001);
        check_eq("trap_no_req", {31'd0, mem_req_valid}, 32'd0);
        check_eq("trap_pending", {29'd0, loads_pending}, 32'd0);
        tick();
        check_eq("trap_exc_pulse", {31'd0, exc_valid}, 32'd0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
